// File: rtl/cpu.sv
// Minimal 16-bit accumulator CPU with unified instruction/data memory `mem`.
// Optional branches (JMP/JZ) are enabled by defining CPU_JUMP_EN.
module cpu #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [15:0]       acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    typedef enum logic {
        FETCH,
        EXEC
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [15:0]       acc;
    logic [15:0]       acc_next;
    logic [15:0]       ir;
    logic [15:0]       ir_next;
    logic              halted_next;
    logic              mem_we;

    logic [15:0]       mem [0:(2**ADDR_W)-1];

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       operand_word;
    logic [11:0]       unused_operand;

    // Operand bits above the address width carry no meaning.
    assign opcode         = ir[15:12];
    assign addr           = ir[ADDR_W-1:0];
    assign unused_operand = ir[11:0];
    assign operand_word   = mem[addr];

    assign acc_out = acc;
    assign pc_out  = pc;

    // Next-state and datapath decode; once halted, every register holds.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        acc_next    = acc;
        ir_next     = ir;
        halted_next = halted;
        mem_we      = 1'b0;
        if (!halted) begin
            case (state)
                FETCH: begin
                    ir_next    = mem[pc];
                    pc_next    = pc + ADDR_W'(1);
                    state_next = EXEC;
                end
                EXEC: begin
                    state_next = FETCH;
                    case (opcode)
                        4'h1: acc_next = acc + operand_word;
                        4'h2: acc_next = ~acc;
                        4'h3: acc_next = acc - operand_word;
                        4'h4: acc_next = acc & operand_word;
                        4'h5: acc_next = acc | operand_word;
`ifdef CPU_JUMP_EN
                        4'h6: pc_next = addr;
                        4'h7: begin
                            if (acc == 16'h0000) begin
                                pc_next = addr;
                            end
                        end
`endif
                        4'h8: acc_next = operand_word;
                        4'h9: mem_we   = 1'b1;
                        4'hF: begin
                            halted_next = 1'b1;
                            state_next  = EXEC;
                        end
                        default: ;
                    endcase
                end
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= '0;
            acc    <= 16'h0000;
            ir     <= 16'h0000;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            acc    <= acc_next;
            ir     <= ir_next;
            halted <= halted_next;
        end
    end

    // Memory has no reset so programs and data survive a CPU reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= acc;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed programs plus randomized programs
// compared against an instruction-level reference model.
module tb_cpu;

    logic        clk;
    logic        reset;
    logic [15:0] acc_out;
    logic [7:0]  pc_out;
    logic        halted;

    int vectorCount = 0;
    int missCount   = 0;

    logic [15:0] modelMem [0:255];

    cpu #(.ADDR_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .acc_out (acc_out),
        .pc_out  (pc_out),
        .halted  (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives reset at a falling edge so release never races a rising edge.
    task automatic applyStimulus(input logic rstLevel);
        @(negedge clk);
        reset = rstLevel;
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectorCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) begin
            dut.mem[i]  = 16'h0000;
            modelMem[i] = 16'h0000;
        end
    endtask

    task automatic pokeMem(input int a, input logic [15:0] d);
        dut.mem[a]  = d;
        modelMem[a] = d;
    endtask

    // Reference interpreter: executes whole instructions on its own memory copy.
    task automatic modelRun(output logic [15:0] macc, output logic [7:0] mpc,
                            output logic mhalt, output int steps);
        logic [15:0] word;
        logic [15:0] m;
        logic [7:0]  ea;
        macc  = 16'h0000;
        mpc   = 8'h00;
        mhalt = 1'b0;
        steps = 0;
        while (!mhalt && steps < 1000) begin
            word = modelMem[mpc];
            mpc  = mpc + 8'd1;
            steps++;
            ea = word[7:0];
            m  = modelMem[ea];
            case (word[15:12])
                4'h1: macc = macc + m;
                4'h2: macc = ~macc;
                4'h3: macc = macc - m;
                4'h4: macc = macc & m;
                4'h5: macc = macc | m;
`ifdef CPU_JUMP_EN
                4'h6: mpc = ea;
                4'h7: if (macc == 16'h0000) mpc = ea;
`endif
                4'h8: macc = m;
                4'h9: modelMem[ea] = macc;
                4'hF: mhalt = 1'b1;
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [15:0] expAcc;
        logic [7:0]  expPc;
        logic        expHalt;
        int          steps;
        logic [3:0]  opList [0:8];

        reset = 1'b1;

        // Load / add / store, halt timing and reset state.
        applyStimulus(1'b1);
        clearMem();
        pokeMem(0, 16'h800A);
        pokeMem(1, 16'h100B);
        pokeMem(2, 16'h900C);
        pokeMem(3, 16'hF000);
        pokeMem(10, 16'h1000);
        pokeMem(11, 16'h000A);
        checkOutput("reset_acc", acc_out, 16'h0000);
        checkOutput("reset_pc", {8'h00, pc_out}, 16'h0000);
        checkOutput("reset_halt", {15'h0, halted}, 16'h0000);
        applyStimulus(1'b0);
        runCycles(7);
        checkOutput("las_halt_edge7", {15'h0, halted}, 16'h0000);
        runCycles(1);
        checkOutput("las_halt_edge8", {15'h0, halted}, 16'h0001);
        checkOutput("las_pc", {8'h00, pc_out}, 16'h0004);
        checkOutput("las_mem12", dut.mem[12], 16'h100A);
        checkOutput("las_acc", acc_out, 16'h100A);
        runCycles(6);
        checkOutput("halt_freeze_pc", {8'h00, pc_out}, 16'h0004);
        checkOutput("halt_freeze_acc", acc_out, 16'h100A);

        // Reset asserted mid-EXEC with acc=0x1234.
        applyStimulus(1'b1);
        clearMem();
        pokeMem(0, 16'h8020);
        pokeMem(32, 16'h1234);
        applyStimulus(1'b0);
        runCycles(3);
        checkOutput("midexec_acc_before", acc_out, 16'h1234);
        reset = 1'b1;
        #1;
        checkOutput("midexec_acc", acc_out, 16'h0000);
        checkOutput("midexec_pc", {8'h00, pc_out}, 16'h0000);
        checkOutput("midexec_halt", {15'h0, halted}, 16'h0000);
        checkOutput("midexec_mem_kept", dut.mem[32], 16'h1234);

        // SUB / NOT with wraparound.
        applyStimulus(1'b1);
        clearMem();
        pokeMem(0, 16'h8010);
        pokeMem(1, 16'h2000);
        pokeMem(2, 16'h900D);
        pokeMem(3, 16'h8011);
        pokeMem(4, 16'h3012);
        pokeMem(5, 16'hF000);
        pokeMem(16, 16'h1005);
        pokeMem(17, 16'h0000);
        pokeMem(18, 16'h0001);
        applyStimulus(1'b0);
        runCycles(12);
        checkOutput("not_mem13", dut.mem[13], 16'hEFFA);
        checkOutput("sub_wrap_acc", acc_out, 16'hFFFF);
        checkOutput("subnot_halt", {15'h0, halted}, 16'h0001);

        // All-zero memory: pc wraps, nothing else changes.
        applyStimulus(1'b1);
        clearMem();
        applyStimulus(1'b0);
        runCycles(510);
        checkOutput("zero_pc_ff", {8'h00, pc_out}, 16'h00FF);
        runCycles(1);
        checkOutput("zero_pc_wrap", {8'h00, pc_out}, 16'h0000);
        runCycles(89);
        checkOutput("zero_pc_600", {8'h00, pc_out}, 16'h002C);
        checkOutput("zero_acc", acc_out, 16'h0000);
        checkOutput("zero_halt", {15'h0, halted}, 16'h0000);

        // Branches.
        applyStimulus(1'b1);
        clearMem();
        pokeMem(0, 16'h7020);
        pokeMem(1, 16'h6005);
        pokeMem(5, 16'h6005);
        pokeMem(32, 16'h8030);
        pokeMem(33, 16'h7040);
        pokeMem(34, 16'h6005);
        pokeMem(48, 16'h0001);
        applyStimulus(1'b0);
`ifdef CPU_JUMP_EN
        runCycles(2);
        checkOutput("jz_taken_pc", {8'h00, pc_out}, 16'h0020);
        runCycles(4);
        checkOutput("jz_fall_pc", {8'h00, pc_out}, 16'h0022);
        checkOutput("jz_fall_acc", acc_out, 16'h0001);
        runCycles(2);
        checkOutput("jmp_pc", {8'h00, pc_out}, 16'h0005);
        runCycles(10);
        checkOutput("jmp_loop_pc", {8'h00, pc_out}, 16'h0005);
        checkOutput("jmp_loop_halt", {15'h0, halted}, 16'h0000);
`else
        runCycles(2);
        checkOutput("jz_nop_pc", {8'h00, pc_out}, 16'h0001);
        runCycles(2);
        checkOutput("jmp_nop_pc", {8'h00, pc_out}, 16'h0002);
        checkOutput("jmp_nop_acc", acc_out, 16'h0000);
`endif

        // Bench writes while running take effect when pc arrives.
        applyStimulus(1'b1);
        clearMem();
        pokeMem(16, 16'hBEEF);
        applyStimulus(1'b0);
        runCycles(4);
        checkOutput("live_pc", {8'h00, pc_out}, 16'h0002);
        pokeMem(6, 16'h8010);
        pokeMem(7, 16'hF000);
        runCycles(11);
        checkOutput("live_halt_early", {15'h0, halted}, 16'h0000);
        runCycles(1);
        checkOutput("live_halt", {15'h0, halted}, 16'h0001);
        checkOutput("live_acc", acc_out, 16'hBEEF);
        checkOutput("live_pc_end", {8'h00, pc_out}, 16'h0008);

        // Randomized straight-line programs against the reference model.
        opList = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB};
        for (int t = 0; t < 12; t++) begin
            applyStimulus(1'b1);
            clearMem();
            for (int i = 0; i < 16; i++) begin
                pokeMem(128 + i, 16'($urandom));
            end
            for (int i = 0; i < 16; i++) begin
                logic [3:0] op;
                logic [3:0] hi;
                logic [3:0] lo;
                op = opList[$urandom_range(8, 0)];
                hi = 4'($urandom);
                lo = 4'($urandom);
                pokeMem(i, {op, hi, 4'h8, lo});
            end
            pokeMem(16, 16'hF000);
            modelRun(expAcc, expPc, expHalt, steps);
            applyStimulus(1'b0);
            runCycles(2 * steps);
            checkOutput($sformatf("rand%0d_acc", t), acc_out, expAcc);
            checkOutput($sformatf("rand%0d_pc", t), {8'h00, pc_out}, {8'h00, expPc});
            checkOutput($sformatf("rand%0d_halt", t), {15'h0, halted}, {15'h0, expHalt});
            for (int i = 0; i < 16; i++) begin
                checkOutput($sformatf("rand%0d_mem%0d", t, 128 + i), dut.mem[128 + i],
                            modelMem[128 + i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
